// File: rtl/rf_ctrl_pkg.sv
// Shared types for the reg_file access controller.
package rf_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_RD     = 2'b00,
    OP_WR     = 2'b01,
    OP_ACC_LD = 2'b10,
    OP_ACC_RD = 2'b11
  } rf_op_t;

  typedef enum logic [1:0] {
    S_INIT,
    S_CLEAR,
    S_RUN
  } state_t;

endpackage

// File: rtl/rf_prio_arb.sv
// Two-way fixed-priority arbiter (req0 wins) with a starvation counter that
// force-grants req1 once it has been refused STARVE_MAX consecutive cycles.
module rf_prio_arb #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic valid0,
  input  logic valid1,
  output logic gnt0,
  output logic gnt1
);

  localparam int unsigned CW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  logic [CW-1:0] starve_cnt;
  logic          starved;

  assign starved = (starve_cnt == CW'(STARVE_MAX));

  // Grant decode: req1 only wins when req0 is absent or req1 is starved.
  always_comb begin
    gnt1 = en && valid1 && (!valid0 || starved);
    gnt0 = en && valid0 && !gnt1;
  end

  // Count refused req1 cycles while arbitrating; saturate, clear on any req1 grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (gnt1) begin
      starve_cnt <= '0;
    end else if (en && valid1 && !starved) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rf_access_ctrl.sv
// Sequencer/arbiter owning all reg_file controls: init pulse, clear sweep,
// then one requester op per cycle with 1-cycle read responses.
module rf_access_ctrl
  import rf_ctrl_pkg::*;
#(
  parameter int unsigned W          = 8,
  parameter int unsigned D          = 4,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic         CLK,
  input  logic         reset,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [1:0]   req0_op,
  input  logic [D-1:0] req0_addr,
  input  logic [W-1:0] req0_wdata,
  output logic         rsp0_valid,
  output logic [W-1:0] rsp0_rdata,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [1:0]   req1_op,
  input  logic [D-1:0] req1_addr,
  input  logic [W-1:0] req1_wdata,
  output logic         rsp1_valid,
  output logic [W-1:0] rsp1_rdata,
  output logic         busy,
  output logic         rf_init,
  output logic         rf_write_en,
  output logic [D-1:0] rf_addr,
  output logic [W-1:0] rf_data_in,
  input  logic [W-1:0] rf_data_out,
  input  logic [W-1:0] rf_acc_out
);

  state_t       state, state_next;
  logic [D-1:0] clr_ptr;
  logic         gnt0, gnt1, any_gnt;
  rf_op_t       sel_op;
  logic [D-1:0] sel_addr;
  logic [W-1:0] sel_wdata;
  logic         sel_is_read;
  logic [W-1:0] rd_val;

  rf_prio_arb #(.STARVE_MAX(STARVE_MAX)) u_arb (
    .clk    (CLK),
    .reset  (reset),
    .en     (state == S_RUN),
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .gnt0   (gnt0),
    .gnt1   (gnt1)
  );

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign any_gnt    = gnt0 || gnt1;

  // Select the granted requester's op fields and the value it would read back.
  always_comb begin
    sel_op      = gnt1 ? rf_op_t'(req1_op) : rf_op_t'(req0_op);
    sel_addr    = gnt1 ? req1_addr  : req0_addr;
    sel_wdata   = gnt1 ? req1_wdata : req0_wdata;
    sel_is_read = (sel_op == OP_RD) || (sel_op == OP_ACC_RD);
    rd_val      = (sel_op == OP_RD) ? rf_data_out : rf_acc_out;
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (reset) state <= S_INIT;
    else       state <= state_next;
  end

  // Next-state: one init cycle, a full clear sweep, then run forever.
  always_comb begin
    state_next = state;
    unique case (state)
      S_INIT:  state_next = S_CLEAR;
      S_CLEAR: if (clr_ptr == '1) state_next = S_RUN;
      S_RUN:   state_next = S_RUN;
      default: state_next = S_INIT;
    endcase
  end

  // Clear pointer walks every address once during S_CLEAR, wrapping to 0.
  always_ff @(posedge CLK) begin
    if (reset)                 clr_ptr <= '0;
    else if (state == S_CLEAR) clr_ptr <= clr_ptr + 1'b1;
  end

  // reg_file control outputs; idle default recirculates acc so it holds.
  always_comb begin
    rf_init     = 1'b0;
    rf_write_en = 1'b0;
    rf_addr     = '0;
    rf_data_in  = rf_acc_out;
    busy        = 1'b1;
    unique case (state)
      S_INIT: begin
        rf_init    = 1'b1;
        rf_data_in = '0;
      end
      S_CLEAR: begin
        rf_write_en = 1'b1;
        rf_addr     = clr_ptr;
        rf_data_in  = '0;
      end
      S_RUN: begin
        busy = 1'b0;
        if (any_gnt) begin
          unique case (sel_op)
            OP_RD:     rf_addr = sel_addr;
            OP_WR: begin
              rf_write_en = 1'b1;
              rf_addr     = sel_addr;
              rf_data_in  = sel_wdata;
            end
            OP_ACC_LD: rf_data_in = sel_wdata;
            OP_ACC_RD: rf_data_in = rf_acc_out;
            default:   rf_data_in = rf_acc_out;
          endcase
        end
      end
      default: busy = 1'b1;
    endcase
  end

  // Read responses: one-cycle pulse after a read grant; data held otherwise.
  always_ff @(posedge CLK) begin
    if (reset) begin
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_rdata <= '0;
      rsp1_rdata <= '0;
    end else begin
      rsp0_valid <= gnt0 && sel_is_read;
      rsp1_valid <= gnt1 && sel_is_read;
      if (gnt0 && sel_is_read) rsp0_rdata <= rd_val;
      if (gnt1 && sel_is_read) rsp1_rdata <= rd_val;
    end
  end

endmodule

// File: tb/tb_rf_access_ctrl.sv
// Self-checking bench for rf_access_ctrl with a behavioural reg_file attached.
module tb_rf_access_ctrl;

  localparam logic [1:0] RD = 2'b00, WR = 2'b01, ALD = 2'b10, ARD = 2'b11;

  logic       CLK = 1'b0;
  logic       reset;
  logic       req0_valid, req0_ready, rsp0_valid;
  logic [1:0] req0_op;
  logic [3:0] req0_addr;
  logic [7:0] req0_wdata, rsp0_rdata;
  logic       req1_valid, req1_ready, rsp1_valid;
  logic [1:0] req1_op;
  logic [3:0] req1_addr;
  logic [7:0] req1_wdata, rsp1_rdata;
  logic       busy, rf_init, rf_write_en;
  logic [3:0] rf_addr;
  logic [7:0] rf_data_in, rf_data_out, rf_acc_out;

  int total = 0;
  int bad   = 0;
  int unsigned cyc = 0;

  rf_access_ctrl #(.W(8), .D(4), .STARVE_MAX(4)) dut (
    .CLK(CLK), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .busy(busy), .rf_init(rf_init), .rf_write_en(rf_write_en),
    .rf_addr(rf_addr), .rf_data_in(rf_data_in),
    .rf_data_out(rf_data_out), .rf_acc_out(rf_acc_out)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Behavioural accumulator register file: acc loads on every non-write edge.
  logic [7:0] mem [16];
  logic [7:0] acc;
  logic       junk_load;
  always @(posedge CLK) begin
    if (junk_load) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'hA0 + 8'(i);
      acc <= 8'hC3;
    end else if (rf_init) begin
      acc <= 8'h00;
    end else if (rf_write_en) begin
      mem[rf_addr] <= rf_data_in;
    end else begin
      acc <= rf_data_in;
    end
  end
  assign rf_data_out = mem[rf_addr];
  assign rf_acc_out  = acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: expected read responses with the cycle they must appear in.
  typedef struct { logic [7:0] data; int unsigned due; } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  task automatic push(input int p, input logic [7:0] d, input int unsigned due);
    exp_t e;
    e.data = d;
    e.due  = due;
    if (p == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic mon_port(input int p, input logic v, input logic [7:0] d);
    exp_t e;
    int   n;
    n = (p == 0) ? q0.size() : q1.size();
    if (v) begin
      if (n == 0) begin
        check(p == 0 ? "rsp0_unexpected" : "rsp1_unexpected", 32'(v), 32'd0);
      end else begin
        e = (p == 0) ? q0.pop_front() : q1.pop_front();
        check(p == 0 ? "rsp0_latency" : "rsp1_latency", cyc, e.due);
        check(p == 0 ? "rsp0_rdata" : "rsp1_rdata", 32'(d), 32'(e.data));
      end
    end else if (n != 0) begin
      e = (p == 0) ? q0[0] : q1[0];
      if (e.due <= cyc) begin
        if (p == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
        check(p == 0 ? "rsp0_missing" : "rsp1_missing", 32'(v), 32'd1);
      end
    end
  endtask

  always @(posedge CLK) begin
    #3;
    mon_port(0, rsp0_valid, rsp0_rdata);
    mon_port(1, rsp1_valid, rsp1_rdata);
  end

  task automatic drive(input int p, input logic v, input logic [1:0] op,
                       input logic [3:0] a, input logic [7:0] wd);
    if (p == 0) begin
      req0_valid = v; req0_op = op; req0_addr = a; req0_wdata = wd;
    end else begin
      req1_valid = v; req1_op = op; req1_addr = a; req1_wdata = wd;
    end
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  // Issue one request and wait (bounded) for its handshake; starts/ends at edge+1.
  task automatic issue(input int p, input logic [1:0] op, input logic [3:0] a,
                       input logic [7:0] wd, input logic [7:0] exp);
    bit got = 0;
    drive(p, 1'b1, op, a, wd);
    for (int n = 0; n < 20 && !got; n++) begin
      #1;
      if ((p == 0 && req0_ready) || (p == 1 && req1_ready)) begin
        got = 1;
        if (op == RD || op == ARD) push(p, exp, cyc + 1);
      end
      next_cycle();
    end
    drive(p, 1'b0, RD, 4'h0, 8'h00);
    check("handshake_timeout", 32'(got), 32'd1);
  endtask

  // Checks the init cycle and the 16-cycle clear sweep; entered at edge+1 of S_INIT.
  task automatic check_sweep();
    check("init_rf_init", 32'(rf_init), 32'd1);
    check("init_busy", 32'(busy), 32'd1);
    check("init_we", 32'(rf_write_en), 32'd0);
    check("init_data_in", 32'(rf_data_in), 32'd0);
    check("init_ready1", 32'(req1_ready), 32'd0);
    next_cycle();
    for (int i = 0; i < 16; i++) begin
      check("clr_we", 32'(rf_write_en), 32'd1);
      check("clr_addr", 32'(rf_addr), 32'(i));
      check("clr_data_in", 32'(rf_data_in), 32'd0);
      check("clr_busy", 32'(busy), 32'd1);
      check("clr_rf_init", 32'(rf_init), 32'd0);
      check("clr_ready1", 32'(req1_ready), 32'd0);
      if (i == 15) begin
        drive(0, 1'b0, RD, 4'h0, 8'h00);
        drive(1, 1'b0, RD, 4'h0, 8'h00);
      end
      next_cycle();
    end
    check("run_busy", 32'(busy), 32'd0);
    check("run_rf_init", 32'(rf_init), 32'd0);
    check("run_idle_we", 32'(rf_write_en), 32'd0);
    check("run_idle_addr", 32'(rf_addr), 32'd0);
    check("run_idle_ready0", 32'(req0_ready), 32'd0);
  endtask

  typedef struct {
    int         p;
    logic [1:0] op;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[12];
  logic r0, r1, exp1;

  initial begin
    tbl[0]  = '{0, WR,  4'd3,  8'hA5, 8'h00};
    tbl[1]  = '{0, RD,  4'd3,  8'h00, 8'hA5};
    tbl[2]  = '{1, WR,  4'd9,  8'h5A, 8'h00};
    tbl[3]  = '{1, RD,  4'd9,  8'h00, 8'h5A};
    tbl[4]  = '{0, ALD, 4'd0,  8'h96, 8'h00};
    tbl[5]  = '{1, ARD, 4'd0,  8'h00, 8'h96};
    tbl[6]  = '{0, WR,  4'd0,  8'hFF, 8'h00};
    tbl[7]  = '{1, RD,  4'd0,  8'h00, 8'hFF};
    tbl[8]  = '{0, RD,  4'd15, 8'h00, 8'h00};
    tbl[9]  = '{1, WR,  4'd15, 8'h81, 8'h00};
    tbl[10] = '{0, RD,  4'd15, 8'h00, 8'h81};
    tbl[11] = '{0, ARD, 4'd0,  8'h00, 8'h96};

    // Junk preload coincides with a one-cycle reset; req1 held valid throughout.
    reset = 1'b1;
    junk_load = 1'b1;
    drive(0, 1'b0, RD, 4'h0, 8'h00);
    drive(1, 1'b1, RD, 4'h2, 8'h00);
    next_cycle();
    reset = 1'b0;
    junk_load = 1'b0;
    check_sweep();

    for (int i = 0; i < 16; i++) issue(i % 2, RD, 4'(i), 8'h00, 8'h00);
    issue(0, ARD, 4'h0, 8'h00, 8'h00);

    for (int i = 0; i < 12; i++)
      issue(tbl[i].p, tbl[i].op, tbl[i].addr, tbl[i].wdata, tbl[i].exp);

    // Accumulator must hold through idle cycles.
    issue(0, ALD, 4'h0, 8'h3C, 8'h00);
    for (int i = 0; i < 5; i++) next_cycle();
    issue(0, ARD, 4'h0, 8'h00, 8'h3C);

    // Continuous contention: req1 wins every fifth cycle.
    drive(0, 1'b1, RD, 4'd3, 8'h00);
    drive(1, 1'b1, RD, 4'd9, 8'h00);
    for (int i = 0; i < 20; i++) begin
      #1;
      r0 = req0_ready;
      r1 = req1_ready;
      exp1 = ((i % 5) == 4);
      check("starve_gnt1", 32'(r1), 32'(exp1));
      check("starve_gnt0", 32'(r0), 32'(!exp1));
      if (r0) push(0, 8'hA5, cyc + 1);
      if (r1) push(1, 8'h5A, cyc + 1);
      next_cycle();
    end
    drive(0, 1'b0, RD, 4'h0, 8'h00);
    drive(1, 1'b0, RD, 4'h0, 8'h00);

    // Simultaneous writes to the same address: req0 first, req1 second.
    drive(0, 1'b1, WR, 4'd7, 8'h11);
    drive(1, 1'b1, WR, 4'd7, 8'h22);
    #1;
    check("wr7_first_gnt0", 32'(req0_ready), 32'd1);
    check("wr7_first_gnt1", 32'(req1_ready), 32'd0);
    next_cycle();
    drive(0, 1'b0, RD, 4'h0, 8'h00);
    #1;
    check("wr7_second_gnt1", 32'(req1_ready), 32'd1);
    next_cycle();
    drive(1, 1'b0, RD, 4'h0, 8'h00);
    issue(0, RD, 4'd7, 8'h00, 8'h22);

    // Reset sampled on the edge that ends a RD grant: response dropped.
    drive(0, 1'b1, RD, 4'd3, 8'h00);
    #1;
    check("rst_rd_gnt", 32'(req0_ready), 32'd1);
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    drive(0, 1'b0, RD, 4'h0, 8'h00);
    check("rst_rsp0_dropped", 32'(rsp0_valid), 32'd0);
    check("rst_rsp0_rdata", 32'(rsp0_rdata), 32'd0);
    check_sweep();
    issue(0, RD, 4'd3, 8'h00, 8'h00);
    issue(1, ARD, 4'd0, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) next_cycle();

    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
